hdmi_axi_waddr: RTL

//  Write-side address generator for the DRAM frame buffer; mirror of the HDMI-out read-address path.

---
 rtl/hdmi_axi_waddr_pkg.sv | 26 ++
 rtl/hdmi_axi_waddr.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hdmi_axi_waddr_pkg.sv
// Shared definitions for the frame-buffer address generators (write and read side):
// FSM state encodings, default burst length and the raster byte-address calculation.
package hdmi_axi_waddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DATA  = 3'd1,
    S_ISSUE_IDLE = 3'd2,
    S_ISSUE      = 3'd3,
    S_ISSUE_WAIT = 3'd4,
    S_FRAME_DONE = 3'd5
  } state_t;

  localparam logic [11:0] WORD_SIZE_DEF = 12'd64;

  // base + (x + y*xsize)*4, all 32-bit unsigned; the line product is widened before scaling
  function automatic logic [31:0] calc_addr(input logic [31:0] base,
                                            input logic [11:0] x,
                                            input logic [11:0] y,
                                            input logic [11:0] xsize);
    logic [31:0] line_off;
    line_off = 32'(y) * 32'(xsize);
    return base + ((32'(x) + line_off) << 2);
  endfunction

endpackage

// File: rtl/hdmi_axi_waddr.sv
// Write-side DRAM frame-buffer address generator. Counts pixels pushed into the
// external write FIFO and issues one WORD_SIZE-word burst per WORD_SIZE pixels,
// walking the frame in raster order; stops after Y_SIZE lines until the next frame_start.
// Optional double buffering: define WADDR_DBLBUF_EN to alternate between two frame
// buffers and expose frame_sel (the buffer most recently completed).
module hdmi_axi_waddr
  import hdmi_axi_waddr_pkg::*;
#(
  parameter logic [11:0] X_SIZE    = 12'd256,
  parameter logic [11:0] Y_SIZE    = 12'd256,
  parameter logic [11:0] WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          PEND_W    = 12
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic        busy,
  output logic        kick,
  output logic [31:0] write_addr,
  output logic [31:0] write_num,
  output logic        frame_done,
  output logic        overflow
`ifdef WADDR_DBLBUF_EN
  ,
  output logic        frame_sel
`endif
);

  localparam logic [PEND_W-1:0] WORD_P = PEND_W'(WORD_SIZE);

  state_t              state;
  logic [11:0]         x_cnt, y_cnt;
  logic [PEND_W-1:0]   pend, pend_acc;
  logic                ovf_set;
  logic                restart_q;
  logic                restart;
  logic [31:0]         base;

  assign write_num = 32'(WORD_SIZE);

`ifdef WADDR_DBLBUF_EN
  localparam logic [31:0] FRAME_BYTES = 32'(X_SIZE) * 32'(Y_SIZE) * 32'd4;
  logic buf_sel;
  assign base = buf_sel ? (BASE_ADDR + FRAME_BYTES) : BASE_ADDR;
`else
  assign base = BASE_ADDR;
`endif

  // Pixel accounting outside a burst: saturate at all-ones and flag overflow
  always_comb begin
    pend_acc = pend;
    ovf_set  = 1'b0;
    if (pixel_valid) begin
      if (&pend) ovf_set  = 1'b1;
      else       pend_acc = pend + 1'b1;
    end
  end

  // A new frame is taken immediately unless a burst is outstanding; then it waits
  // until the controller has accepted the command
  always_comb begin
    restart = 1'b0;
    case (state)
      S_IDLE, S_WAIT_DATA, S_ISSUE_IDLE, S_FRAME_DONE: restart = frame_start;
      S_ISSUE_WAIT: restart = busy && (restart_q || frame_start);
      default:      restart = 1'b0;
    endcase
  end

  // Burst-issue FSM with registered kick/write_addr/frame_done outputs
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      kick       <= 1'b0;
      write_addr <= BASE_ADDR;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      pend       <= '0;
      restart_q  <= 1'b0;
`ifdef WADDR_DBLBUF_EN
      buf_sel    <= 1'b1;
      frame_sel  <= 1'b1;
`endif
    end else if (restart) begin
      state      <= S_WAIT_DATA;
      kick       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      pend       <= PEND_W'(pixel_valid);
      restart_q  <= 1'b0;
`ifdef WADDR_DBLBUF_EN
      buf_sel    <= ~buf_sel;
`endif
    end else begin
      case (state)
        S_WAIT_DATA: begin
          pend     <= pend_acc;
          overflow <= overflow | ovf_set;
          if (pend >= WORD_P) state <= S_ISSUE_IDLE;
        end
        S_ISSUE_IDLE: begin
          pend       <= pend_acc;
          overflow   <= overflow | ovf_set;
          write_addr <= calc_addr(base, x_cnt, y_cnt, X_SIZE);
          if (!busy) begin
            state <= S_ISSUE;
            kick  <= 1'b1;
          end
        end
        S_ISSUE: begin
          // burst consumes WORD_SIZE pixels; a pixel arriving now still counts
          pend  <= pend - WORD_P + PEND_W'(pixel_valid);
          state <= S_ISSUE_WAIT;
          if (frame_start) restart_q <= 1'b1;
          if (x_cnt == X_SIZE - WORD_SIZE) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 12'd1;
          end else begin
            x_cnt <= x_cnt + WORD_SIZE;
          end
        end
        S_ISSUE_WAIT: begin
          pend     <= pend_acc;
          overflow <= overflow | ovf_set;
          if (frame_start) restart_q <= 1'b1;
          if (busy) begin
            kick <= 1'b0;
            if (y_cnt == Y_SIZE) begin
              state      <= S_FRAME_DONE;
              frame_done <= 1'b1;
`ifdef WADDR_DBLBUF_EN
              frame_sel  <= buf_sel;
`endif
            end else begin
              state <= S_WAIT_DATA;
            end
          end
        end
        S_IDLE, S_FRAME_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
